// File: rtl/punc_mc_control_pkg.sv
// Opcode, state and datapath-select encodings for the PUnC control FSM, shared with the datapath.
// PUNC_SINGLE_STEP_EN adds the STEP state to the state encoding.
package punc_mc_control_pkg;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
    OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
    OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
    OP_JMP = 4'b1100, OP_HLT = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
  } opcode_t;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM1, ST_MEM2, ST_HALT, ST_FAULT
`ifdef PUNC_SINGLE_STEP_EN
    , ST_STEP
`endif
  } state_t;

  localparam logic [1:0] ADDR_PC  = 2'b00, ADDR_ALU  = 2'b01, ADDR_MAR = 2'b10;
  localparam logic [1:0] PCS_OFF9 = 2'b00, PCS_OFF11 = 2'b01, PCS_BASER = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b10, ALU_PASS = 2'b11;
  localparam logic       A_SR1    = 1'b0,  A_PC = 1'b1;
  localparam logic [1:0] B_SR2    = 2'b00, B_IMM5 = 2'b01, B_OFF9 = 2'b10, B_OFF6 = 2'b11;
  localparam logic [1:0] WB_ALU   = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_addr_sel;
    logic       ir_ld;
    logic       mar_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_sel;
    logic [1:0] alu_op;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic       rf_we;
    logic       cc_we;
    logic [1:0] rf_wsel;
    logic       rf_dst_r7;
    logic       instr_retired;
    logic       halted;
    logic       fault;
  } ctrl_t;

  // LDR/STR form their address from SR1+off6; every other memory op uses PC+off9.
  function automatic logic is_base_addr(opcode_t op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

  function automatic logic is_store(opcode_t op);
    return (op == OP_ST) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/punc_mc_control_if.sv
// Control-to-datapath/memory signal bundle; master is the control FSM, slave is datapath + memory port.
interface punc_mc_control_if;
  logic [15:0] ir;
  logic        br_taken;
  logic        mem_ack;
  logic        step_req;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_addr_sel;
  logic        ir_ld;
  logic        mar_ld;
  logic        pc_clr;
  logic        pc_inc;
  logic        pc_ld;
  logic [1:0]  pc_sel;
  logic [1:0]  alu_op;
  logic        alu_a_sel;
  logic [1:0]  alu_b_sel;
  logic        rf_we;
  logic        cc_we;
  logic [1:0]  rf_wsel;
  logic        rf_dst_r7;
  logic        instr_retired;
  logic        halted;
  logic        fault;

  modport master (
    input  ir, br_taken, mem_ack, step_req,
    output mem_req, mem_we, mem_addr_sel, ir_ld, mar_ld, pc_clr, pc_inc, pc_ld, pc_sel,
           alu_op, alu_a_sel, alu_b_sel, rf_we, cc_we, rf_wsel, rf_dst_r7,
           instr_retired, halted, fault
  );

  modport slave (
    output ir, br_taken, mem_ack, step_req,
    input  mem_req, mem_we, mem_addr_sel, ir_ld, mar_ld, pc_clr, pc_inc, pc_ld, pc_sel,
           alu_op, alu_a_sel, alu_b_sel, rf_we, cc_we, rf_wsel, rf_dst_r7,
           instr_retired, halted, fault
  );
endinterface

// File: rtl/punc_mc_control_mem_timer.sv
// Memory wait-state counter: cleared outside a request or on ack, counts unacknowledged request cycles.
// expired flags the cycle the count reaches MEM_TIMEOUT; MEM_TIMEOUT = 0 never expires.
module punc_mc_control_mem_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

  assign expired = (MEM_TIMEOUT != 0) && (cnt == TMR_W'(MEM_TIMEOUT));
endmodule

// File: rtl/punc_mc_control.sv
// Multi-cycle LC3 control FSM: outputs decode combinationally from registered state, ir and mem_ack.
// PUNC_SINGLE_STEP_EN inserts a STEP state after every retire, released by step_req.
module punc_mc_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  punc_mc_control_if.master    bus
);
  import punc_mc_control_pkg::*;

`ifdef PUNC_SINGLE_STEP_EN
  localparam state_t RET_NXT = ST_STEP;
`else
  localparam state_t RET_NXT = ST_FETCH;
`endif

  state_t  state, state_nxt;
  ctrl_t   ctrl;
  opcode_t op;
  logic    in_req, tmr_exp;

  assign op     = opcode_t'(bus.ir[15:12]);
  assign in_req = state inside {ST_FETCH, ST_MEM1, ST_MEM2};

  punc_mc_control_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_req || bus.mem_ack),
    .inc     (in_req && !bus.mem_ack),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    case (state)
      ST_RESET: begin
        ctrl.pc_clr = 1'b1;
        state_nxt   = ST_FETCH;
      end
      ST_FETCH: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = ADDR_PC;
        if (bus.mem_ack) begin
          ctrl.ir_ld = 1'b1;
          state_nxt  = ST_DECODE;
        end else if (tmr_exp) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_DECODE: begin
        ctrl.pc_inc = 1'b1;
        state_nxt   = ST_EXEC;
      end
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT: begin
            ctrl.alu_op        = (op == OP_ADD) ? ALU_ADD : (op == OP_AND) ? ALU_AND : ALU_NOT;
            ctrl.alu_b_sel     = bus.ir[5] ? B_IMM5 : B_SR2;
            ctrl.rf_we         = 1'b1;
            ctrl.cc_we         = 1'b1;
            ctrl.instr_retired = 1'b1;
            state_nxt          = RET_NXT;
          end
          OP_LEA: begin
            ctrl.alu_a_sel     = A_PC;
            ctrl.alu_b_sel     = B_OFF9;
            ctrl.alu_op        = ALU_ADD;
            ctrl.rf_we         = 1'b1;
            ctrl.cc_we         = 1'b1;
            ctrl.instr_retired = 1'b1;
            state_nxt          = RET_NXT;
          end
          OP_BR: begin
            ctrl.pc_ld         = bus.br_taken;
            ctrl.pc_sel        = PCS_OFF9;
            ctrl.instr_retired = 1'b1;
            state_nxt          = RET_NXT;
          end
          OP_JMP: begin
            ctrl.pc_ld         = 1'b1;
            ctrl.pc_sel        = PCS_BASER;
            ctrl.instr_retired = 1'b1;
            state_nxt          = RET_NXT;
          end
          // BaseR is read before the R7 link write lands, so JSRR R7 jumps to the old R7.
          OP_JSR: begin
            ctrl.rf_we         = 1'b1;
            ctrl.rf_wsel       = WB_PC;
            ctrl.rf_dst_r7     = 1'b1;
            ctrl.pc_ld         = 1'b1;
            ctrl.pc_sel        = bus.ir[11] ? PCS_OFF11 : PCS_BASER;
            ctrl.instr_retired = 1'b1;
            state_nxt          = RET_NXT;
          end
          OP_LD, OP_LDR, OP_ST, OP_STR, OP_LDI, OP_STI: begin
            ctrl.alu_op    = ALU_ADD;
            ctrl.alu_a_sel = is_base_addr(op) ? A_SR1 : A_PC;
            ctrl.alu_b_sel = is_base_addr(op) ? B_OFF6 : B_OFF9;
            state_nxt      = ST_MEM1;
          end
          OP_HLT:  state_nxt = ST_HALT;
          default: state_nxt = ST_FAULT;
        endcase
      end
      ST_MEM1: begin
        ctrl.alu_op       = ALU_ADD;
        ctrl.alu_a_sel    = is_base_addr(op) ? A_SR1 : A_PC;
        ctrl.alu_b_sel    = is_base_addr(op) ? B_OFF6 : B_OFF9;
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = ADDR_ALU;
        ctrl.mem_we       = is_store(op);
        if (bus.mem_ack) begin
          case (op)
            OP_LD, OP_LDR: begin
              ctrl.rf_we         = 1'b1;
              ctrl.rf_wsel       = WB_MEM;
              ctrl.cc_we         = 1'b1;
              ctrl.instr_retired = 1'b1;
              state_nxt          = RET_NXT;
            end
            OP_ST, OP_STR: begin
              ctrl.instr_retired = 1'b1;
              state_nxt          = RET_NXT;
            end
            default: begin
              ctrl.mar_ld = 1'b1;
              state_nxt   = ST_MEM2;
            end
          endcase
        end else if (tmr_exp) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_MEM2: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = ADDR_MAR;
        ctrl.mem_we       = (op == OP_STI);
        if (bus.mem_ack) begin
          ctrl.rf_we         = (op == OP_LDI);
          ctrl.rf_wsel       = (op == OP_LDI) ? WB_MEM : WB_ALU;
          ctrl.cc_we         = (op == OP_LDI);
          ctrl.instr_retired = 1'b1;
          state_nxt          = RET_NXT;
        end else if (tmr_exp) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_HALT:  ctrl.halted = 1'b1;
      ST_FAULT: ctrl.fault  = 1'b1;
`ifdef PUNC_SINGLE_STEP_EN
      ST_STEP:  if (bus.step_req) state_nxt = ST_FETCH;
`endif
      default:  state_nxt = ST_RESET;
    endcase
  end

  assign bus.mem_req       = ctrl.mem_req;
  assign bus.mem_we        = ctrl.mem_we;
  assign bus.mem_addr_sel  = ctrl.mem_addr_sel;
  assign bus.ir_ld         = ctrl.ir_ld;
  assign bus.mar_ld        = ctrl.mar_ld;
  assign bus.pc_clr        = ctrl.pc_clr;
  assign bus.pc_inc        = ctrl.pc_inc;
  assign bus.pc_ld         = ctrl.pc_ld;
  assign bus.pc_sel        = ctrl.pc_sel;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.alu_a_sel     = ctrl.alu_a_sel;
  assign bus.alu_b_sel     = ctrl.alu_b_sel;
  assign bus.rf_we         = ctrl.rf_we;
  assign bus.cc_we         = ctrl.cc_we;
  assign bus.rf_wsel       = ctrl.rf_wsel;
  assign bus.rf_dst_r7     = ctrl.rf_dst_r7;
  assign bus.instr_retired = ctrl.instr_retired;
  assign bus.halted        = ctrl.halted;
  assign bus.fault         = ctrl.fault;
endmodule

// File: tb/tb_punc_mc_control.sv
// Scoreboard bench for punc_mc_control (MEM_TIMEOUT=4): per-cycle expected control vectors, monitor compares.
// With PUNC_SINGLE_STEP_EN each retire is followed by a STEP stall released by a step_req pulse.
module tb_punc_mc_control;
  import punc_mc_control_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  punc_mc_control_if bus();

  punc_mc_control #(.MEM_TIMEOUT(4), .TMR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ctrl_t exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;
  ctrl_t act;

  always_comb begin
    act               = '0;
    act.mem_req       = bus.mem_req;
    act.mem_we        = bus.mem_we;
    act.mem_addr_sel  = bus.mem_addr_sel;
    act.ir_ld         = bus.ir_ld;
    act.mar_ld        = bus.mar_ld;
    act.pc_clr        = bus.pc_clr;
    act.pc_inc        = bus.pc_inc;
    act.pc_ld         = bus.pc_ld;
    act.pc_sel        = bus.pc_sel;
    act.alu_op        = bus.alu_op;
    act.alu_a_sel     = bus.alu_a_sel;
    act.alu_b_sel     = bus.alu_b_sel;
    act.rf_we         = bus.rf_we;
    act.cc_we         = bus.cc_we;
    act.rf_wsel       = bus.rf_wsel;
    act.rf_dst_r7     = bus.rf_dst_r7;
    act.instr_retired = bus.instr_retired;
    act.halted        = bus.halted;
    act.fault         = bus.fault;
  end

  // Monitor: one expected vector per driven cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ctrl_t e;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input string n, input logic ack, input ctrl_t e);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.mem_ack  = ack;
    bus.br_taken = 1'b0;
    bus.step_req = 1'b0;
    nm_q.push_back(n);
    exp_q.push_back(e);
  endtask

  function automatic ctrl_t fe(input logic ack);
    ctrl_t r = '0;
    r.mem_req = 1'b1;
    r.ir_ld   = ack;
    return r;
  endfunction

  function automatic ctrl_t mem(input logic [1:0] sel, input logic we);
    ctrl_t r = '0;
    r.mem_req      = 1'b1;
    r.mem_addr_sel = sel;
    r.mem_we       = we;
    return r;
  endfunction

  task automatic fetch(input logic [15:0] instr, input int waits, input string n);
    ctrl_t d = '0;
    d.pc_inc = 1'b1;
    for (int i = 0; i < waits; i++) cyc({n, "_fwait"}, 1'b0, fe(1'b0));
    cyc({n, "_fetch"}, 1'b1, fe(1'b1));
    bus.ir = instr;
    cyc({n, "_decode"}, 1'b0, d);
  endtask

  task automatic step_gap();
`ifdef PUNC_SINGLE_STEP_EN
    cyc("step_idle", 1'b0, ctrl_t'('0));
    cyc("step_go", 1'b0, ctrl_t'('0));
    bus.step_req = 1'b1;
`endif
  endtask

  ctrl_t e, pcclr;

  initial begin
    rst = 1'b1; bus.ir = 16'h0; bus.mem_ack = 1'b0; bus.br_taken = 1'b0; bus.step_req = 1'b0;
    pcclr = '0; pcclr.pc_clr = 1'b1;
    cyc("reset_hold", 1'b0, pcclr); rst = 1'b1;
    cyc("reset_state", 1'b0, pcclr);

    // ADD R1,R2,#3 zero-wait
    fetch(16'h12A3, 0, "add");
    e = '0; e.alu_b_sel = B_IMM5; e.rf_we = 1; e.cc_we = 1; e.instr_retired = 1;
    cyc("add_exec", 1'b0, e); step_gap();

    // AND register form
    fetch(16'h5283, 0, "and");
    e = '0; e.alu_op = 2'b01; e.rf_we = 1; e.cc_we = 1; e.instr_retired = 1;
    cyc("and_exec", 1'b0, e); step_gap();

    // NOT; fetch acked in the very cycle the wait count reaches the timeout
    fetch(16'h967F, 4, "not_ackwins");
    e = '0; e.alu_op = 2'b10; e.alu_b_sel = 2'b01; e.rf_we = 1; e.cc_we = 1; e.instr_retired = 1;
    cyc("not_exec", 1'b0, e); step_gap();

    // BR not taken, then taken
    fetch(16'h0E05, 0, "brn");
    e = '0; e.instr_retired = 1;
    cyc("br_nt_exec", 1'b0, e); step_gap();
    fetch(16'h0E05, 0, "brt");
    e = '0; e.pc_ld = 1; e.pc_sel = 2'b00; e.instr_retired = 1;
    cyc("br_t_exec", 1'b0, e); bus.br_taken = 1'b1; step_gap();

    // JSRR R7 and JSR
    fetch(16'h41C0, 0, "jsrr");
    e = '0; e.rf_we = 1; e.rf_wsel = 2'b10; e.rf_dst_r7 = 1; e.pc_ld = 1; e.pc_sel = 2'b10; e.instr_retired = 1;
    cyc("jsrr_exec", 1'b0, e); step_gap();
    fetch(16'h4805, 0, "jsr");
    e.pc_sel = 2'b01;
    cyc("jsr_exec", 1'b0, e); step_gap();

    // JMP
    fetch(16'hC1C0, 0, "jmp");
    e = '0; e.pc_ld = 1; e.pc_sel = 2'b10; e.instr_retired = 1;
    cyc("jmp_exec", 1'b0, e); step_gap();

    // LDI: 1 fetch wait, 2 MEM1 waits, 3 MEM2 waits
    fetch(16'hA002, 1, "ldi");
    e = '0; e.alu_a_sel = 1; e.alu_b_sel = 2'b10;
    cyc("ldi_exec", 1'b0, e);
    e = mem(2'b01, 1'b0); e.alu_a_sel = 1; e.alu_b_sel = 2'b10;
    cyc("ldi_m1wait", 1'b0, e);
    cyc("ldi_m1wait", 1'b0, e);
    e.mar_ld = 1;
    cyc("ldi_m1ack", 1'b1, e);
    for (int i = 0; i < 3; i++) cyc("ldi_m2wait", 1'b0, mem(2'b10, 1'b0));
    e = mem(2'b10, 1'b0); e.rf_we = 1; e.rf_wsel = 2'b01; e.cc_we = 1; e.instr_retired = 1;
    cyc("ldi_m2ack", 1'b1, e); step_gap();

    // ST zero-wait
    fetch(16'h3005, 0, "st");
    e = '0; e.alu_a_sel = 1; e.alu_b_sel = 2'b10;
    cyc("st_exec", 1'b0, e);
    e = mem(2'b01, 1'b1); e.alu_a_sel = 1; e.alu_b_sel = 2'b10; e.instr_retired = 1;
    cyc("st_m1ack", 1'b1, e); step_gap();

    // LDR zero-wait
    fetch(16'h6042, 0, "ldr");
    e = '0; e.alu_b_sel = 2'b11;
    cyc("ldr_exec", 1'b0, e);
    e = mem(2'b01, 1'b0); e.alu_b_sel = 2'b11; e.rf_we = 1; e.rf_wsel = 2'b01; e.cc_we = 1; e.instr_retired = 1;
    cyc("ldr_m1ack", 1'b1, e); step_gap();

    // STI aborted by reset during MEM2 wait
    fetch(16'hB003, 0, "sti");
    e = '0; e.alu_a_sel = 1; e.alu_b_sel = 2'b10;
    cyc("sti_exec", 1'b0, e);
    e = mem(2'b01, 1'b0); e.alu_a_sel = 1; e.alu_b_sel = 2'b10; e.mar_ld = 1;
    cyc("sti_m1ack", 1'b1, e);
    cyc("sti_m2wait", 1'b0, mem(2'b10, 1'b1));
    cyc("sti_m2wait_rst", 1'b0, mem(2'b10, 1'b1)); rst = 1'b1;
    cyc("sti_abort_reset", 1'b0, pcclr);
    cyc("post_reset_fetch", 1'b0, fe(1'b0));
    fetch(16'h12A3, 0, "add2");
    e = '0; e.alu_b_sel = B_IMM5; e.rf_we = 1; e.cc_we = 1; e.instr_retired = 1;
    cyc("add2_exec", 1'b0, e); step_gap();

    // HLT is terminal until reset
    fetch(16'hD000, 0, "hlt");
    cyc("hlt_exec", 1'b0, ctrl_t'('0));
    e = '0; e.halted = 1;
    cyc("halted", 1'b1, e);
    cyc("halted_hold", 1'b0, e); rst = 1'b1;
    cyc("hlt_reset", 1'b0, pcclr);

    // TRAP faults
    fetch(16'hF025, 0, "trap");
    cyc("trap_exec", 1'b0, ctrl_t'('0));
    e = '0; e.fault = 1;
    cyc("trap_fault", 1'b0, e); rst = 1'b1;
    cyc("trap_reset", 1'b0, pcclr);

    // Fetch never acked: five request cycles, then sticky fault with mem_req low
    for (int i = 0; i < 5; i++) cyc("timeout_wait", 1'b0, fe(1'b0));
    e = '0; e.fault = 1;
    cyc("timeout_fault", 1'b0, e);
    cyc("timeout_fault_hold", 1'b1, e);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
